// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl: RV32 5-stage forwarding, load-use/branch hazards and mul/div E-stage sequencing.
// Optional HAZARD_PERF_EN adds saturating StallCycles/FlushCount counters.
module hazard_sched_ctrl #(
  parameter int MULDIV_LAT = 4
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       MemReadE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulDivStart,
  output logic       MulDivBusy
`ifdef HAZARD_PERF_EN
  , output logic [PERF_W-1:0] StallCycles
  , output logic [PERF_W-1:0] FlushCount
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic lw_stall, start, hold, lw_eff, br_eff;
  always_comb begin
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    lw_stall = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    start = state == IDLE && MulDivE;
    hold = start || state == BUSY;
    // the FSM owns the pipeline while holding: hazards and branches wait
    br_eff = PCSrcE && !hold;
    lw_eff = lw_stall && !PCSrcE && state == IDLE && !MulDivE;
    StallF = hold || lw_eff;
    StallD = hold || lw_eff;
    StallE = hold;
    FlushD = br_eff;
    FlushE = br_eff || lw_eff;
    FlushM = hold;
    MulDivStart = start;
    MulDivBusy = state != IDLE;
    state_n = start ? BUSY : state == BUSY ? (cnt == 6'd1 ? DONE : BUSY) : IDLE;
    cnt_n = start ? 6'(MULDIV_LAT - 1) : (state == BUSY && cnt != 6'd1) ? cnt - 6'd1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCycles <= '0;
      FlushCount <= '0;
    end else begin
      StallCycles <= (StallF && !(&StallCycles)) ? StallCycles + PERF_W'(1) : StallCycles;
      FlushCount <= ((FlushD || FlushE) && !(&FlushCount)) ? FlushCount + PERF_W'(1) : FlushCount;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// tb_hazard_sched_ctrl: scoreboard bench over three instances (MULDIV_LAT 4, 2, 8) sharing one stimulus.
module tb_hazard_sched_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
  logic MemReadE = 0, RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MulDivE = 0;
  logic [11:0] ov [3];
  logic [31:0] sc [3], fc [3];
  localparam int LATS [3] = '{4, 2, 8};
  // observed vector: {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivStart, MulDivBusy}
  localparam logic [11:0] IDL = 12'h000, START = 12'b0000_1110_0110, BSY = 12'b0000_1110_0101,
                          DN = 12'b0000_0000_0001, LW = 12'b0000_1100_1000, BR = 12'b0000_0001_1000;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm, st, bz;
    hazard_sched_ctrl #(.MULDIV_LAT(LATS[g])) u_dut (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
      .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se),
      .FlushD(fd), .FlushE(fe), .FlushM(fm), .MulDivStart(st), .MulDivBusy(bz)
`ifdef HAZARD_PERF_EN
      , .StallCycles(sc[g]), .FlushCount(fc[g])
`endif
    );
    assign ov[g] = {fa, fb, sf, sd, se, fd, fe, fm, st, bz};
`ifndef HAZARD_PERF_EN
    assign sc[g] = '0;
    assign fc[g] = '0;
`endif
  end
  typedef struct {string tag; int id; logic [11:0] v;} exp_t;
  exp_t q [$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(string tag, int id, logic [11:0] v);
    q.push_back('{tag, id, v});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("%s[lat%0d]", e.tag, LATS[e.id]), 32'(ov[e.id]), 32'(e.v));
    end
  always @(posedge clk)
    if (!rst) assert (!(PCSrcE && MulDivE)) else $error("illegal PCSrcE with MulDivE");
  task automatic clear_in;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {MemReadE, RegWriteM, RegWriteW, PCSrcE, MulDivE} = '0;
  endtask
  task automatic do_reset;
    rst = 1;
    clear_in();
    tick();
    for (int i = 0; i < 3; i++) push("in_rst", i, IDL);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) push("post_rst", i, IDL);
    tick();
  endtask
  initial begin
    do_reset();
    RdM = 3; RegWriteM = 1; RdW = 3; RegWriteW = 1; Rs1E = 3; Rs2E = 3;
    push("fwd_m", 0, 12'b1010_0000_0000); tick();
    RegWriteM = 0;
    push("fwd_w", 0, 12'b0101_0000_0000); tick();
    RdM = 0; RdW = 0; RegWriteM = 1;
    push("fwd_x0", 0, IDL); tick();
    Rs2E = 4; RdM = 4; RdW = 3;
    push("fwd_mix", 0, 12'b0110_0000_0000); tick();
    clear_in();
    MemReadE = 1; RdE = 5; Rs2D = 5;
    push("lw", 0, LW); tick();
    PCSrcE = 1;
    push("lw_br", 0, BR); tick();
    PCSrcE = 0; Rs2D = 0; Rs1D = 5;
    push("lw_rs1", 0, LW); tick();
    RdE = 0; Rs1D = 0;
    push("lw_x0", 0, IDL); tick();
    clear_in();
    MulDivE = 1; MemReadE = 1; RdE = 5; Rs2D = 5;
    push("md4_c0", 0, START); tick();
    for (int c = 1; c < 4; c++) begin
      push($sformatf("md4_c%0d", c), 0, BSY);
      tick();
    end
    MemReadE = 0; RdE = 0; Rs2D = 0;
    push("md4_done", 0, DN); tick();
    MulDivE = 0;
    push("md4_idle", 0, IDL); tick();
    do_reset();
    MulDivE = 1;
    for (int k = 0; k < 2; k++) begin
      push($sformatf("md2_start%0d", k), 1, START); tick();
      push($sformatf("md2_busy%0d", k), 1, BSY); tick();
      push($sformatf("md2_done%0d", k), 1, DN); tick();
    end
    MulDivE = 0;
    push("md2_idle", 1, IDL); tick();
    do_reset();
    MulDivE = 1;
    push("md8_start", 2, START); tick();
    push("md8_busy1", 2, BSY); tick();
    rst = 1; MulDivE = 0;
    push("md8_rstcyc", 2, BSY); tick();
    rst = 0;
    push("md8_after_rst", 2, IDL); tick();
    MulDivE = 1;
    push("md8_restart", 2, START); tick();
    for (int c = 1; c < 8; c++) begin
      push($sformatf("md8_c%0d", c), 2, BSY);
      tick();
    end
    push("md8_done", 2, DN); tick();
    MulDivE = 0;
    push("md8_idle", 2, IDL); tick();
`ifdef HAZARD_PERF_EN
    do_reset();
    check("perf_stall_rst", sc[0], 0);
    check("perf_flush_rst", fc[0], 0);
    MemReadE = 1; RdE = 5; Rs2D = 5;
    push("perf_lw", 0, LW); tick();
    clear_in();
    PCSrcE = 1;
    push("perf_br", 0, BR); tick();
    PCSrcE = 0; MulDivE = 1;
    push("perf_md_start", 0, START); tick();
    for (int c = 1; c < 4; c++) begin
      push("perf_md_busy", 0, BSY);
      tick();
    end
    push("perf_md_done", 0, DN); tick();
    MulDivE = 0;
    push("perf_idle", 0, IDL); tick();
    check("perf_stall", sc[0], 5);
    check("perf_flush", fc[0], 2);
`endif
    tick();
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
